// File: rtl/red_seq_ctrl.sv
// Byte-reduction (RED) sequencer: three passes through one shared 8-bit adder,
// with valid/ready handshakes on the operand and result sides.
module red_seq_ctrl #(
  parameter int DATA_W   = 16,
  parameter bit SIGN_EXT = 1'b1,
  parameter int CNT_W    = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] red_res,
  output logic              busy,
  output logic [CNT_W-1:0]  done_cnt
);

  if (DATA_W != 16) begin : g_bad_width
    $error("red_seq_ctrl: DATA_W must be 16");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_SUM_A,
    S_SUM_B,
    S_SUM_AB,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              accept;
  logic              handoff;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [7:0]        acc_a;
  logic [7:0]        acc_b;
  logic [7:0]        add_x;
  logic [7:0]        add_y;
  logic [7:0]        add_s;
  logic [DATA_W-1:0] res_ext;

  // flush overrides both handshakes: nothing is captured and nothing is counted.
  assign accept  = in_valid & in_ready & ~flush;
  assign handoff = out_valid & out_ready & ~flush;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  // NOTE: every combinationally written signal gets a default first, so no latch is inferred.
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = S_IDLE;
    end else begin
      unique case (state)
        S_IDLE:   if (accept) state_nxt = S_SUM_A;
        S_SUM_A:  state_nxt = S_SUM_B;
        S_SUM_B:  state_nxt = S_SUM_AB;
        S_SUM_AB: state_nxt = S_DONE;
        S_DONE:   if (out_ready) state_nxt = in_valid ? S_SUM_A : S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // Output logic.
  always_comb begin
    out_valid = (state == S_DONE);
    busy      = (state != S_IDLE);
    in_ready  = (state == S_IDLE) | ((state == S_DONE) & out_ready);
  end

  // Shared adder: operand pair selected by the current pass; carry-out is dropped.
  always_comb begin
    add_x = '0;
    add_y = '0;
    case (state)
      S_SUM_A: begin
        add_x = a_q[7:0];
        add_y = a_q[15:8];
      end
      S_SUM_B: begin
        add_x = b_q[7:0];
        add_y = b_q[15:8];
      end
      S_SUM_AB: begin
        add_x = acc_a;
        add_y = acc_b;
      end
      default: ;
    endcase
    add_s = add_x + add_y;
  end

  assign res_ext = SIGN_EXT ? {{(DATA_W-8){add_s[7]}}, add_s}
                            : {{(DATA_W-8){1'b0}}, add_s};

  // Datapath registers.
  // NOTE: all datapath registers are reset, so red_res and the accumulators read 0 after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      acc_a   <= '0;
      acc_b   <= '0;
      red_res <= '0;
    end else begin
      if (accept) begin
        a_q <= op_a;
        b_q <= op_b;
      end
      if (!flush) begin
        case (state)
          S_SUM_A:  acc_a   <= add_s;
          S_SUM_B:  acc_b   <= add_s;
          S_SUM_AB: red_res <= res_ext;
          default: ;
        endcase
      end
    end
  end

  // Completed-operation counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      done_cnt <= '0;
    end else if (handoff) begin
      done_cnt <= done_cnt + CNT_W'(1);
    end
  end

endmodule
